// File: rtl/sr_mem_pkg.sv
// Shared types and helpers for the shift-register ring memory request port.
package sr_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Forward distance around a ring of n locations from 'from' to 'to'.
  function automatic int ring_dist(input int to, input int from, input int n);
    int d;
    d = to - from;
    if (d < 0) d = d + n;
    return d;
  endfunction

  // Width of the WAIT watchdog counter.
  function automatic int wdog_width(input int num_locs, input int data_width);
    return $clog2(2 * num_locs * data_width) + 1;
  endfunction

endpackage

// File: rtl/sr_step_calc.sv
// Relative step count from the buffered ring location to an absolute target,
// plus an out-of-range flag for targets beyond the ring.
module sr_step_calc
  import sr_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int NUM_LOCS      = 16
) (
  input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [ADDRESS_WIDTH-1:0] cur_addr_i,
  output logic [ADDRESS_WIDTH-1:0] steps_o,
  output logic                     oor_o
);

  assign steps_o = ADDRESS_WIDTH'(ring_dist(int'(req_addr_i), int'(cur_addr_i), NUM_LOCS));
  assign oor_o   = int'(req_addr_i) >= NUM_LOCS;

endmodule

// File: rtl/sr_mem_port.sv
// Absolute-address request port for the shift-register ring memory controller.
// Optional WAIT watchdog enabled by defining SR_MEM_PORT_TIMEOUT_EN.
module sr_mem_port
  import sr_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_LOCS      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_write_i,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0]    req_wdata_i,
  output logic                     rsp_valid_o,
  output logic [DATA_WIDTH-1:0]    rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic                     sr_start_o,
  output logic                     sr_write_o,
  output logic [ADDRESS_WIDTH-1:0] sr_steps_o,
  output logic [DATA_WIDTH-1:0]    sr_value_o,
  input  logic                     sr_last_i,
  input  logic [DATA_WIDTH-1:0]    sr_buffer_i,
  output logic [ADDRESS_WIDTH-1:0] cur_addr_o
);

  state_e                   state_q, state_d;
  logic                     write_q, err_q;
  logic [ADDRESS_WIDTH-1:0] addr_q, steps_q, cur_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [ADDRESS_WIDTH-1:0] steps_c;
  logic                     oor_c, accept, timeout, busy;

  sr_step_calc #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .NUM_LOCS     (NUM_LOCS)
  ) u_step (
    .req_addr_i(req_addr_i),
    .cur_addr_i(cur_q),
    .steps_o   (steps_c),
    .oor_o     (oor_c)
  );

  assign accept = (state_q == ST_IDLE) && req_valid_i;

`ifdef SR_MEM_PORT_TIMEOUT_EN
  localparam int WdogW   = wdog_width(NUM_LOCS, DATA_WIDTH);
  localparam int WdogLim = 2 * NUM_LOCS * DATA_WIDTH;
  logic [WdogW-1:0] wdog_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                wdog_q <= '0;
    else if (state_q == ST_WAIT) wdog_q <= wdog_q + WdogW'(1);
    else                         wdog_q <= '0;
  end

  assign timeout = (state_q == ST_WAIT) && (wdog_q == WdogW'(WdogLim - 1));
`else
  assign timeout = 1'b0;
`endif

  // Out-of-range targets skip the controller and answer straight away.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid_i) state_d = oor_c ? ST_RESP : ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (sr_last_i || timeout) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      steps_q <= '0;
      wdata_q <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr_i;
        write_q <= req_write_i & ~oor_c;
        wdata_q <= oor_c ? '0 : req_wdata_i;
        steps_q <= oor_c ? '0 : steps_c;
        err_q   <= oor_c;
      end else if (timeout && !sr_last_i) begin
        err_q   <= 1'b1;
      end
      // A failed access leaves the ring where it was.
      if (state_q == ST_RESP && !err_q) cur_q <= addr_q;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign req_ready_o = (state_q == ST_IDLE);
  assign sr_start_o  = (state_q == ST_LAUNCH);
  assign sr_write_o  = busy & write_q;
  assign sr_steps_o  = busy ? steps_q : '0;
  assign sr_value_o  = busy ? wdata_q : '0;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_err_o   = rsp_valid_o & err_q;
  assign rsp_rdata_o = (rsp_valid_o && !err_q) ? sr_buffer_i : '0;
  assign cur_addr_o  = cur_q;

endmodule

// File: tb/tb_sr_mem_port.sv
// Scoreboard bench for sr_mem_port against a behavioural ring controller.
`timescale 1ns/1ps
module tb_sr_mem_port;
  localparam int AW = 4, DW = 8, NL = 16, NL12 = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 0, req_write = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_err, sr_start, sr_write, sr_last;
  logic [DW-1:0] rsp_rdata, sr_value, sr_buffer;
  logic [AW-1:0] sr_steps, cur_addr;

  logic          v12 = 0, wr12 = 0;
  logic [AW-1:0] addr12 = '0;
  logic [DW-1:0] wd12 = '0;
  logic          rdy12, rspv12, err12, start12, srw12;
  logic [DW-1:0] rdata12, srval12;
  logic [AW-1:0] steps12, cur12;

  sr_mem_port #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LOCS(NL)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .sr_start_o(sr_start), .sr_write_o(sr_write), .sr_steps_o(sr_steps),
    .sr_value_o(sr_value), .sr_last_i(sr_last), .sr_buffer_i(sr_buffer),
    .cur_addr_o(cur_addr));

  sr_mem_port #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LOCS(NL12)) dut12 (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(v12), .req_ready_o(rdy12),
    .req_write_i(wr12), .req_addr_i(addr12), .req_wdata_i(wd12),
    .rsp_valid_o(rspv12), .rsp_rdata_o(rdata12), .rsp_err_o(err12),
    .sr_start_o(start12), .sr_write_o(srw12), .sr_steps_o(steps12),
    .sr_value_o(srval12), .sr_last_i(1'b0), .sr_buffer_i(8'h5A),
    .cur_addr_o(cur12));

  int n_chk = 0, n_fail = 0, cyc = 0, nrsp = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural ring controller: the buffer shows location 'pos'; a start
  // rotates by sr_steps, and lastStep comes after steps*DW active cycles.
  logic [DW-1:0] seed [NL];
  logic [DW-1:0] cmem [NL];
  bit seeded = 0, active = 0, mute = 0;
  int pos = 0, cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (!seeded) begin
        for (int i = 0; i < NL; i++) cmem[i] <= seed[i];
        seeded <= 1'b1;
      end
      pos <= 0; active <= 1'b0; cnt <= 0;
    end else if (!active) begin
      if (sr_start) begin
        active <= 1'b1;
        cnt    <= int'(sr_steps) * DW;
        pos    <= (pos + int'(sr_steps)) % NL;
        if (sr_write) cmem[(pos + int'(sr_steps)) % NL] <= sr_value;
      end
    end else if (cnt != 0) cnt <= cnt - 1;
    else if (!sr_start) active <= 1'b0;
  end
  assign sr_last   = active && (cnt == 0) && !mute;
  assign sr_buffer = cmem[pos];

  // Reference: absolute-address memory and the location last reached.
  typedef struct {
    int steps; logic [DW-1:0] rdata; logic err; logic wr; logic [DW-1:0] val;
    int cur; int acc; int lat;
  } exp_t;
  exp_t sbq[$];
  logic [DW-1:0] ref_mem [NL];
  int ref_cur = 0;

  task automatic send(input bit wr, input int addr, input logic [DW-1:0] d,
                      input bit hold, input bit tmo);
    exp_t e;
    int w;
    @(negedge clk);
    req_valid = 1; req_write = wr; req_addr = AW'(addr); req_wdata = d;
    w = 0;
    while (!req_ready && w < 2000) begin @(negedge clk); w++; end
    if (w >= 2000) begin chk("accept_timeout", 0, 1); req_valid = 0; return; end
    e.steps = (addr - ref_cur + NL) % NL;
    e.wr = wr; e.val = d; e.acc = cyc + 1;
    if (tmo) begin
      e.rdata = '0; e.err = 1; e.cur = ref_cur; e.lat = 2 + 2 * NL * DW;
    end else begin
      e.rdata = wr ? d : ref_mem[addr]; e.err = 0; e.cur = addr;
      e.lat = e.steps * DW + 3;
      if (wr) ref_mem[addr] = d;
      ref_cur = addr;
    end
    sbq.push_back(e);
    @(posedge clk);
    if (!hold) begin #1 req_valid = 0; end
  endtask

  task automatic drain();
    int w = 0;
    while ((sbq.size() != 0 || !req_ready) && w < 1000) begin @(negedge clk); w++; end
    if (w >= 1000) chk("drain_timeout", sbq.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every response.
  bit prev_rsp = 0, prev_start = 0, cur_chk = 0;
  int start_cnt = 0, cur_exp = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete(); start_cnt = 0; cur_chk = 0; prev_rsp = 0; prev_start = 0;
    end else begin
      if (cur_chk) begin chk("cur_addr", cur_addr, cur_exp); cur_chk = 0; end
      if (sr_start) begin chk("sr_start_width", prev_start, 0); start_cnt++; end
      if (req_ready) chk("idle_sr_zero", {sr_write, sr_steps, sr_value}, 0);
      if (rsp_valid) begin
        chk("rsp_double", prev_rsp, 0);
        if (sbq.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
          chk("sr_steps", sr_steps, e.steps);
          chk("sr_write", sr_write, e.wr);
          if (e.wr) chk("sr_value", sr_value, e.val);
          chk("latency", cyc - e.acc + 1, e.lat);
          chk("start_count", start_cnt, 1);
          chk("ready_in_resp", req_ready, 0);
          cur_exp = e.cur; cur_chk = 1; start_cnt = 0; nrsp++;
        end
      end
      prev_rsp = rsp_valid; prev_start = sr_start;
    end
  end

  bit start12_seen = 0;
  always @(negedge clk) if (start12) start12_seen = 1;

  initial begin
    int base;
    int oor_addrs[3];
    for (int i = 0; i < NL; i++) begin
      seed[i] = 8'($urandom); ref_mem[i] = seed[i];
    end
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_sr_start", sr_start, 0);
    chk("rst_sr_out", {sr_write, sr_steps, sr_value}, 0);
    chk("rst_cur_addr", cur_addr, 0);
    #2 rst_n = 1;

    send(0, 5, 8'h00, 0, 0);
    send(0, 12, 8'h00, 0, 0);
    send(1, 3, 8'hA7, 0, 0);
    send(0, 3, 8'h00, 0, 0);
    drain();

    // Reset during WAIT of a 9-step read.
    send(0, 4, 8'h00, 0, 0);
    drain();
    send(0, 13, 8'h00, 0, 0);
    repeat (12) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_sr_start", sr_start, 0);
    chk("abort_cur_addr", cur_addr, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    ref_cur = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    repeat (100) @(negedge clk);

    // Continuous req_valid, alternating targets.
    base = nrsp;
    for (int k = 0; k < 6; k++) send(0, (k % 2) ? 9 : 2, 8'h00, k < 5, 0);
    drain();
    chk("hold_rsp_count", nrsp - base, 6);

    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(1'($urandom), $urandom_range(0, NL - 1), 8'($urandom), 0, 0);
    end
    drain();

`ifdef SR_MEM_PORT_TIMEOUT_EN
    mute = 1;
    send(0, 7, 8'h00, 0, 1);
    drain();
    mute = 0;
    @(negedge clk); #2 rst_n = 0;
    @(negedge clk); #2 rst_n = 1;
    ref_cur = 0;
    repeat (2) @(negedge clk);
`endif

    // Out-of-range targets on the 12-location instance.
    oor_addrs[0] = 15; oor_addrs[1] = 12; oor_addrs[2] = 13;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("oor_ready_before", rdy12, 1);
      v12 = 1; wr12 = 1; addr12 = AW'(oor_addrs[k]); wd12 = 8'hFF;
      @(posedge clk); #1 v12 = 0;
      @(negedge clk);
      chk("oor_rsp_valid", rspv12, 1);
      chk("oor_rsp_err", err12, 1);
      chk("oor_rsp_rdata", rdata12, 0);
      chk("oor_cur_addr", cur12, 0);
      @(negedge clk);
      chk("oor_rsp_pulse", rspv12, 0);
      chk("oor_idle_sr_zero", {srw12, steps12, srval12}, 0);
    end
    chk("oor_no_start", start12_seen, 0);
    chk("sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/sr_mem_port.md
# sr_mem_port

Request-side initiator for the shift-register ring memory controller. It accepts absolute-address read/write requests on a valid/ready interface, keeps track of which ring location currently sits in the controller's buffer, converts each request into a relative step count, and runs the controller's start/lastStep handshake. It returns the buffer contents as the response. It sits between the 2048 game-logic FSM and the ring memory, so the game logic never reasons about ring position.

## Interface
- `ADDRESS_WIDTH`, 4: width of absolute addresses and of `sr_steps`.
- `DATA_WIDTH`, 8: width of one memory location.
- `NUM_LOCS`, 16: ring length, counting the buffer location. Must satisfy 2 ≤ NUM_LOCS ≤ 2^ADDRESS_WIDTH.
- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request. High only in IDLE.
- `req_write`  in  1  1 = write `req_wdata`, 0 = read.
- `req_addr`  in  ADDRESS_WIDTH  absolute target location.
- `req_wdata`  in  DATA_WIDTH  write data.
- `rsp_valid`  out  1  one-cycle pulse when the response is ready.
- `rsp_rdata`  out  DATA_WIDTH  buffer contents after the access. For a write this is the written value.
- `rsp_err`  out  1  qualifies `rsp_valid`. Set for an out-of-range address or a timeout.
- `sr_start`  out  1  controller start.
- `sr_write`  out  1  controller write.
- `sr_steps`  out  ADDRESS_WIDTH  relative step count to the controller.
- `sr_value`  out  DATA_WIDTH  controller write value.
- `sr_last`  in  1  controller lastStep.
- `sr_buffer`  in  DATA_WIDTH  controller buffer.
- `cur_addr`  out  ADDRESS_WIDTH  location currently held in the buffer.

## Operation
- States:
  - IDLE → LAUNCH on `req_valid`.
  - LAUNCH → WAIT, always.
  - WAIT → RESP on `sr_last`.
  - RESP → IDLE, always.
  - With SR_MEM_PORT_TIMEOUT_EN only: WAIT → RESP on timeout.
- Acceptance happens on the edge where `req_valid && req_ready`. At that edge the block latches `req_write`, `req_addr` and `req_wdata`.
- Step computation: `sr_steps = (req_addr − cur_addr) mod NUM_LOCS`.
  - Compute it in ADDRESS_WIDTH+1 bits: add NUM_LOCS when the difference is negative.
  - Register it at acceptance.
  - Same address gives 0 steps.
- Out-of-range address (`req_addr ≥ NUM_LOCS`):
  - The request is accepted.
  - No controller transaction is started.
  - Next cycle: `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0`. `cur_addr` is unchanged.
- LAUNCH: `sr_start=1` for exactly one cycle. In every other state `sr_start=0`, which lets the controller deactivate on `sr_last`.
- `sr_write`, `sr_value` and `sr_steps` are held stable from LAUNCH through RESP inclusive. In IDLE they are 0.
- WAIT: exits on the first cycle `sr_last` is sampled high. A zero-step access exits after 1 WAIT cycle.
- RESP:
  - `rsp_valid=1` and `rsp_rdata=sr_buffer` sampled this cycle.
  - `cur_addr` takes the latched `req_addr`.
  - `rsp_err=0`.
- Back-to-back: `req_ready` rises in the cycle after RESP. There is no overlap between requests.

## Timing
- Reset values: all state and outputs reset to 0.
  - State = IDLE; `req_ready=1` after reset.
  - `cur_addr=0`, `sr_start=0`, `sr_write=0`, `sr_steps=0`, `sr_value=0`.
  - `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`.
- Latency, for a controller that asserts lastStep after steps×DATA_WIDTH active cycles:
  - acceptance edge → `rsp_valid` = steps×DATA_WIDTH + 3 cycles.
  - Out-of-range address: 1 cycle.
- `rsp_valid` never stays high for two consecutive cycles.
- Reset asserted mid-transaction: immediate return to IDLE, outputs go to reset values, and `cur_addr=0`. This matches the ring state the controller holds after its own reset.
- `req_valid` is ignored outside IDLE. The requester must hold the request until it is accepted.

## Configuration
- `SR_MEM_PORT_TIMEOUT_EN` defined:
  - A watchdog counter runs in WAIT.
  - When it reaches 2×NUM_LOCS×DATA_WIDTH cycles: RESP with `rsp_err=1`, `rsp_rdata=0`, `cur_addr` unchanged.
- Not defined: there is no watchdog, WAIT lasts until `sr_last`, and `rsp_err` is set only for out-of-range addresses.

## Structure
- Package `sr_mem_pkg` holds:
  - the state enum (IDLE, LAUNCH, WAIT, RESP);
  - the ring-distance function;
  - the watchdog width constant, `$clog2(2*NUM_LOCS*DATA_WIDTH)+1`.
- One sub-module, `sr_step_calc`: combinational modular distance from (`req_addr`, `cur_addr`, `NUM_LOCS`) to steps, plus an out-of-range flag.
- The top level holds the FSM, the request latches, `cur_addr` and the watchdog.

## Test plan
- Reset, then read addr 5 against a behavioural controller model:
  - `sr_steps=5`, `sr_start` high for 1 cycle;
  - `rsp_valid` 43 cycles after acceptance (DATA_WIDTH=8);
  - `rsp_rdata` = model content at location 5; `cur_addr=5`.
- From `cur_addr=12`, write 0xA7 to addr 3:
  - `sr_steps=7`, `sr_write`/`sr_value` held through RESP;
  - `rsp_rdata=0xA7`;
  - a subsequent read of addr 3 (0 steps) returns 0xA7 after 3 cycles.
- `req_addr=15` with NUM_LOCS=12: no `sr_start`, `rsp_err=1` one cycle after acceptance, `cur_addr` unchanged.
- Assert `rst_n` low during WAIT of a 9-step access: `sr_start=0`, `cur_addr=0`, `req_ready=1` immediately, and no `rsp_valid` pulse.
- `SR_MEM_PORT_TIMEOUT_EN` defined, model never raises `sr_last`: `rsp_valid` with `rsp_err=1` after 256 WAIT cycles (NUM_LOCS=16, DATA_WIDTH=8).
- Hold `req_valid` continuously with alternating addresses 2/9: exactly one `rsp_valid` per request, and `req_ready` low from acceptance through RESP.
